// File: rtl/stim_loader_if.sv
// Host byte link and STIM_FIFO / DI_FIFO write ports of the stimulus loader.
// master = loader side, slave = host receiver and FIFO side.
interface stim_loader_if #(
   parameter int unsigned STF_WIDTH = 24,
   parameter int unsigned DIF_WIDTH = 32
);
   logic [7:0]           in_data;
   logic                 in_valid;
   logic                 in_ready;
   logic [STF_WIDTH-1:0] sfifo_data;
   logic                 sfifo_wrreq;
   logic                 sfifo_wrfull;
   logic [DIF_WIDTH-1:0] dififo_data;
   logic                 dififo_wrreq;
   logic                 dififo_wrfull;

   modport master (
      input  in_data, in_valid, sfifo_wrfull, dififo_wrfull,
      output in_ready, sfifo_data, sfifo_wrreq, dififo_data, dififo_wrreq
   );

   modport slave (
      output in_data, in_valid, sfifo_wrfull, dififo_wrfull,
      input  in_ready, sfifo_data, sfifo_wrreq, dififo_data, dififo_wrreq
   );
endinterface

// File: rtl/stim_loader.sv
// Parses the host byte stream into stimulus vectors (STIM_FIFO) and DI commands
// (DI_FIFO); header 00 = stimulus, FF = end-of-stream, anything else = command.
module stim_loader #(
   parameter int unsigned STF_WIDTH = 24,
   parameter int unsigned REQ_WIDTH = 3,
   parameter int unsigned CMD_WIDTH = 5,
   parameter int unsigned DIF_WIDTH = REQ_WIDTH + CMD_WIDTH + STF_WIDTH,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 clock,
   input  logic                 reset_n,
   stim_loader_if.master        bus,
   output logic                 done,
   output logic [CNT_WIDTH-1:0] vec_count,
   output logic [CNT_WIDTH-1:0] cmd_count
);
   localparam int unsigned HDR_WIDTH = REQ_WIDTH + CMD_WIDTH;
   localparam int unsigned NB        = STF_WIDTH / 8;
   localparam int unsigned BC_WIDTH  = $clog2(NB) + 1;
   localparam logic [BC_WIDTH-1:0] LAST_BYTE = BC_WIDTH'(NB - 1);

   localparam logic [1:0] HDR     = 2'd0;
   localparam logic [1:0] PAYLOAD = 2'd1;
   localparam logic [1:0] WRITE   = 2'd2;
   localparam logic [1:0] DONE    = 2'd3;

   logic [1:0]           state;
   logic [HDR_WIDTH-1:0] header_q;
   logic [STF_WIDTH-1:0] payload_q;
   logic [BC_WIDTH-1:0]  byte_cnt;
   logic                 accept;
   logic                 to_stim;
   logic                 s_wr;
   logic                 d_wr;

   assign bus.in_ready = (state == HDR) || (state == PAYLOAD);
   assign accept       = bus.in_valid && bus.in_ready;
   assign to_stim      = (header_q == '0);

   // Write strobes are combinational so a record leaves in the cycle after its last byte.
   assign s_wr = (state == WRITE) &&  to_stim && !bus.sfifo_wrfull;
   assign d_wr = (state == WRITE) && !to_stim && !bus.dififo_wrfull;

   assign bus.sfifo_wrreq  = s_wr;
   assign bus.dififo_wrreq = d_wr;
   assign bus.sfifo_data   = payload_q;
   assign bus.dififo_data  = DIF_WIDTH'({header_q, payload_q});
   assign done             = (state == DONE);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= HDR;
         header_q  <= '0;
         payload_q <= '0;
         byte_cnt  <= '0;
      end else begin
         case (state)
            HDR: if (accept) begin
               header_q <= HDR_WIDTH'(bus.in_data);
               byte_cnt <= '0;
               state    <= (bus.in_data == 8'hFF) ? DONE : PAYLOAD;
            end
            PAYLOAD: if (accept) begin
               payload_q <= {payload_q[STF_WIDTH-9:0], bus.in_data};
               byte_cnt  <= byte_cnt + BC_WIDTH'(1);
               if (byte_cnt == LAST_BYTE) state <= WRITE;
            end
            WRITE: if (s_wr || d_wr) state <= HDR;
            default: state <= DONE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vec_count <= '0;
         cmd_count <= '0;
      end else begin
         if (s_wr && (vec_count != '1)) vec_count <= vec_count + CNT_WIDTH'(1);
         if (d_wr && (cmd_count != '1)) cmd_count <= cmd_count + CNT_WIDTH'(1);
      end
   end
endmodule

// File: tb/tb_stim_loader.sv
// Bench for stim_loader: record-level reference model checked every cycle,
// directed scenarios with literal expectations, and a randomized gapped stream.
module tb_stim_loader;
   localparam int unsigned CW  = 5;
   localparam int unsigned SAT = (1 << CW) - 1;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          done;
   logic [CW-1:0] vec_count;
   logic [CW-1:0] cmd_count;

   stim_loader_if #(.STF_WIDTH(24), .DIF_WIDTH(32)) bus_if ();

   stim_loader #(
      .STF_WIDTH(24),
      .REQ_WIDTH(3),
      .CMD_WIDTH(5),
      .CNT_WIDTH(CW)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .bus       (bus_if),
      .done      (done),
      .vec_count (vec_count),
      .cmd_count (cmd_count)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // FIFO full flags: either forced by the directed tests or randomized per cycle
   logic force_s = 1'b0, force_d = 1'b0, rand_full = 1'b0, rnd_s = 1'b0, rnd_d = 1'b0;
   assign bus_if.sfifo_wrfull  = rand_full ? rnd_s : force_s;
   assign bus_if.dififo_wrfull = rand_full ? rnd_d : force_d;

   always @(posedge clock) begin
      #1;
      rnd_s = ($urandom_range(0, 2) == 0);
      rnd_d = ($urandom_range(0, 2) == 0);
   end

   // Reference model: bytes accepted so far in the current record, one pending record
   logic [7:0]  m_rec[$];
   bit          m_pend = 0, m_done = 0;
   logic [7:0]  m_hdr;
   logic [23:0] m_pay;
   int unsigned m_vec = 0, m_cmd = 0;
   logic [23:0] s_log[$];
   logic [31:0] d_log[$];
   int          s_pulses = 0;

   always @(negedge clock) begin
      bit exp_rdy, exp_sw, exp_dw;
      if (bus_if.sfifo_wrreq === 1'b1) s_pulses++;
      if (!reset_n) begin
         chk("rst_in_ready", bus_if.in_ready, 1);
         chk("rst_sfifo_wrreq", bus_if.sfifo_wrreq, 0);
         chk("rst_dififo_wrreq", bus_if.dififo_wrreq, 0);
         chk("rst_sfifo_data", bus_if.sfifo_data, 0);
         chk("rst_dififo_data", bus_if.dififo_data, 0);
         chk("rst_done", done, 0);
         chk("rst_vec_count", vec_count, 0);
         chk("rst_cmd_count", cmd_count, 0);
         m_rec.delete();
         m_pend = 0; m_done = 0; m_vec = 0; m_cmd = 0;
      end else begin
         exp_rdy = !m_done && !m_pend;
         exp_sw  = m_pend && (m_hdr == 8'h00) && !bus_if.sfifo_wrfull;
         exp_dw  = m_pend && (m_hdr != 8'h00) && !bus_if.dififo_wrfull;
         chk("in_ready", bus_if.in_ready, exp_rdy);
         chk("sfifo_wrreq", bus_if.sfifo_wrreq, exp_sw);
         chk("dififo_wrreq", bus_if.dififo_wrreq, exp_dw);
         chk("done", done, m_done);
         chk("vec_count", vec_count, m_vec);
         chk("cmd_count", cmd_count, m_cmd);
         if (m_pend) begin
            chk("sfifo_data", bus_if.sfifo_data, m_pay);
            chk("dififo_data", bus_if.dififo_data, {m_hdr, m_pay});
         end
         if (exp_sw) begin
            s_log.push_back(m_pay);
            if (m_vec < SAT) m_vec++;
            m_pend = 0;
         end else if (exp_dw) begin
            d_log.push_back({m_hdr, m_pay});
            if (m_cmd < SAT) m_cmd++;
            m_pend = 0;
         end else if (exp_rdy && bus_if.in_valid) begin
            m_rec.push_back(bus_if.in_data);
            if (m_rec.size() == 1 && m_rec[0] == 8'hFF) begin
               m_done = 1;
               m_rec.delete();
            end else if (m_rec.size() == 4) begin
               m_hdr = m_rec[0];
               m_pay = (24'(m_rec[1]) << 16) | (24'(m_rec[2]) << 8) | 24'(m_rec[3]);
               m_pend = 1;
               m_rec.delete();
            end
         end
      end
   end

   bit gap_en = 0;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic idle(input int n);
      bus_if.in_valid = 1'b0;
      step(n);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int  n = 0;
      bit  acc = 0;
      if (gap_en) idle($urandom_range(0, 3));
      bus_if.in_data  = b;
      bus_if.in_valid = 1'b1;
      do begin
         @(negedge clock);
         acc = (bus_if.in_ready === 1'b1);
         @(posedge clock);
         #1;
         n++;
      end while (!acc && n < 200);
      if (!acc) chk("accept_timeout", 0, 1);
   endtask

   task automatic send_rec(input logic [7:0] h, input logic [23:0] p);
      send_byte(h);
      send_byte(p[23:16]);
      send_byte(p[15:8]);
      send_byte(p[7:0]);
   endtask

   task automatic wait_idle();
      int n = 0;
      bus_if.in_valid = 1'b0;
      while (m_pend && n < 200) begin
         step(1);
         n++;
      end
      chk("drain_timeout", m_pend, 0);
      step(2);
   endtask

   task automatic do_reset();
      bus_if.in_valid = 1'b0;
      reset_n = 1'b0;
      step(3);
      reset_n = 1'b1;
      step(1);
   endtask

   function automatic logic [23:0] s_at(input int i);
      return (i < s_log.size()) ? s_log[i] : 24'hxxxxxx;
   endfunction

   function automatic logic [31:0] d_at(input int i);
      return (i < d_log.size()) ? d_log[i] : 32'hxxxxxxxx;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      int n_stim;
      logic [7:0]  h;
      logic [23:0] p;
      bus_if.in_data  = 8'h00;
      bus_if.in_valid = 1'b0;
      reset_n = 1'b0;
      step(3);
      reset_n = 1'b1;
      step(1);

      // Stimulus record, in_valid held high across the record
      p0 = s_pulses;
      send_rec(8'h00, 24'h123456);
      wait_idle();
      chk("A_s_count", s_log.size(), 1);
      chk("A_s_data", s_at(0), 24'h123456);
      chk("A_pulses", s_pulses - p0, 1);
      chk("A_no_di", d_log.size(), 0);
      chk("A_vec", vec_count, 1);

      // DI command
      send_rec(8'h01, 24'h000005);
      wait_idle();
      chk("B_d_count", d_log.size(), 1);
      chk("B_d_data", d_at(0), 32'h01000005);
      chk("B_cmd", cmd_count, 1);

      // STIM_FIFO full for 10 cycles
      s_log.delete();
      force_s = 1'b1;
      send_rec(8'h00, 24'hAABBCC);
      idle(10);
      chk("C_held_no_write", s_log.size(), 0);
      chk("C_held_in_ready", bus_if.in_ready, 0);
      force_s = 1'b0;
      wait_idle();
      chk("C_s_count", s_log.size(), 1);
      chk("C_s_data", s_at(0), 24'hAABBCC);
      chk("C_vec", vec_count, 2);

      // DI_FIFO full must not stall a stimulus record
      s_log.delete();
      force_d = 1'b1;
      send_rec(8'h00, 24'h010203);
      idle(2);
      chk("C2_s_data", s_at(0), 24'h010203);
      chk("C2_vec", vec_count, 3);
      force_d = 1'b0;

      // Reset in the middle of a record
      s_log.delete();
      d_log.delete();
      send_byte(8'h00);
      send_byte(8'h11);
      do_reset();
      chk("R_vec_cleared", vec_count, 0);
      send_rec(8'h00, 24'h445566);
      wait_idle();
      chk("R_s_count", s_log.size(), 1);
      chk("R_s_data", s_at(0), 24'h445566);
      chk("R_vec", vec_count, 1);

      // End of stream, then bytes that must be ignored
      s_log.delete();
      send_byte(8'hFF);
      bus_if.in_data = 8'h00; step(5);
      bus_if.in_data = 8'h11; step(5);
      bus_if.in_data = 8'h22; step(5);
      bus_if.in_data = 8'h33; step(5);
      chk("D_done", done, 1);
      chk("D_in_ready", bus_if.in_ready, 0);
      chk("D_no_writes", s_log.size() + d_log.size(), 0);
      chk("D_vec", vec_count, 1);
      chk("D_cmd", cmd_count, 0);
      idle(3);
      chk("D_done_sticky", done, 1);
      do_reset();
      chk("D_done_cleared", done, 0);

      // Gapped three-record stream
      s_log.delete();
      d_log.delete();
      gap_en = 1;
      send_rec(8'h00, 24'hA1A2A3);
      send_rec(8'h05, 24'hB1B2B3);
      send_rec(8'h00, 24'hC1C2C3);
      wait_idle();
      chk("G_s_count", s_log.size(), 2);
      chk("G_s0", s_at(0), 24'hA1A2A3);
      chk("G_s1", s_at(1), 24'hC1C2C3);
      chk("G_d0", d_at(0), 32'h05B1B2B3);

      // Random records with random gaps and random full flags
      do_reset();
      s_log.delete();
      d_log.delete();
      rand_full = 1;
      n_stim = 0;
      for (int i = 0; i < 40; i++) begin
         h = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 254));
         p = 24'($urandom);
         if (h == 8'h00) n_stim++;
         send_rec(h, p);
      end
      wait_idle();
      rand_full = 0;
      gap_en = 0;
      chk("X_s_count", s_log.size(), n_stim);
      chk("X_d_count", d_log.size(), 40 - n_stim);

      // Counter saturation
      do_reset();
      for (int i = 0; i < 35; i++) send_rec(8'h00, 24'(i));
      wait_idle();
      chk("S_vec_sat", vec_count, 5'h1F);
      chk("S_cmd", cmd_count, 0);

      idle(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
